// File: rtl/sum3_share_arb.sv
// Round-robin arbiter that shares one registered three-operand adder among
// NUM_REQ requesters and returns each result tagged with the requester index.
module sum3_share_arb #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*WIDTH-1:0] req_c,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_ovf,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   op_c;
  logic [ID_W-1:0]    op_id;

  logic [WIDTH-1:0]   a_arr [NUM_REQ];
  logic [WIDTH-1:0]   b_arr [NUM_REQ];
  logic [WIDTH-1:0]   c_arr [NUM_REQ];

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant_vec;
  logic [ID_W-1:0]    next_ptr;
  logic [WIDTH+1:0]   full;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    assign c_arr[i] = req_c[i*WIDTH +: WIDTH];
  end

  // Search upward from rr_ptr with wrap; the first valid requester wins.
  always_comb begin
    int      pos;
    logic [ID_W-1:0] cand;
    pos         = 0;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    if (rst_n && state == IDLE) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        pos = int'(rr_ptr) + k;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        cand = ID_W'(pos);
        if (!grant_found && req_valid[cand]) begin
          grant_found     = 1'b1;
          grant_idx       = cand;
          grant_vec[cand] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant_vec;
  assign next_ptr  = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
  assign full      = {2'b00, op_a} + {2'b00, op_b} + {2'b00, op_c};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_c      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_ovf   <= 1'b0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a   <= a_arr[grant_idx];
            op_b   <= b_arr[grant_idx];
            op_c   <= c_arr[grant_idx];
            op_id  <= grant_idx;
            rr_ptr <= next_ptr;
            state  <= CALC;
            busy   <= 1'b1;
          end
        end
        CALC: begin
          rsp_sum   <= full[WIDTH-1:0];
          rsp_ovf   <= |full[WIDTH+1:WIDTH];
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // Result fields stay put after the handshake; only valid drops.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum3_share_arb.sv
// Directed self-checking bench for sum3_share_arb (NUM_REQ=4, WIDTH=8).
module tb_sum3_share_arb;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*WIDTH-1:0] req_c;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_ovf;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;

  int total = 0;
  int bad   = 0;

  sum3_share_arb #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
    req_c[idx*WIDTH +: WIDTH] = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges with every requester valid; grants must stay suppressed.
  task automatic doReset(input string tag);
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    step();
    step();
    checkOutput({tag, ".ready_in_reset"}, 32'(req_ready), 32'h0);
    checkOutput({tag, ".rsp_valid"},      32'(rsp_valid), 32'h0);
    checkOutput({tag, ".rsp_sum"},        32'(rsp_sum),   32'h0);
    checkOutput({tag, ".rsp_ovf"},        32'(rsp_ovf),   32'h0);
    checkOutput({tag, ".rsp_id"},         32'(rsp_id),    32'h0);
    checkOutput({tag, ".busy"},           32'(busy),      32'h0);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
  endtask

  // One full grant -> CALC -> RESP -> handshake sequence, three cycles long.
  task automatic runTxn(input string tag, input logic [3:0] mask, input logic [3:0] exp_grant,
                        input logic [7:0] exp_sum, input logic exp_ovf, input logic [1:0] exp_id);
    req_valid = mask;
    #1;
    checkOutput({tag, ".grant"}, 32'(req_ready), 32'(exp_grant));
    step();
    checkOutput({tag, ".busy_calc"},  32'(busy),      32'h1);
    checkOutput({tag, ".ready_calc"}, 32'(req_ready), 32'h0);
    checkOutput({tag, ".valid_calc"}, 32'(rsp_valid), 32'h0);
    step();
    checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h1);
    checkOutput({tag, ".rsp_sum"},   32'(rsp_sum),   32'(exp_sum));
    checkOutput({tag, ".rsp_ovf"},   32'(rsp_ovf),   32'(exp_ovf));
    checkOutput({tag, ".rsp_id"},    32'(rsp_id),    32'(exp_id));
    rsp_ready = 1'b1;
    step();
    checkOutput({tag, ".valid_done"}, 32'(rsp_valid), 32'h0);
    checkOutput({tag, ".busy_done"},  32'(busy),      32'h0);
    checkOutput({tag, ".sum_held"},   32'(rsp_sum),   32'(exp_sum));
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    #2;
    doReset("reset");

    // Basic path
    applyStimulus(0, 8'd1, 8'd2, 8'd3);
    runTxn("basic", 4'b0001, 4'b0001, 8'd6, 1'b0, 2'd0);

    // Overflow, then the largest non-overflowing sum
    applyStimulus(2, 8'd255, 8'd255, 8'd255);
    runTxn("ovf", 4'b0100, 4'b0100, 8'hFD, 1'b1, 2'd2);
    applyStimulus(2, 8'd200, 8'd55, 8'd0);
    runTxn("no_ovf", 4'b0100, 4'b0100, 8'hFF, 1'b0, 2'd2);

    // Round-robin with everybody valid, starting from a fresh pointer
    doReset("reset2");
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 8'(i), 8'd0, 8'd0);
    runTxn("rr0", 4'b1111, 4'b0001, 8'd0, 1'b0, 2'd0);
    runTxn("rr1", 4'b1111, 4'b0010, 8'd1, 1'b0, 2'd1);
    runTxn("rr2", 4'b1111, 4'b0100, 8'd2, 1'b0, 2'd2);
    runTxn("rr3", 4'b1111, 4'b1000, 8'd3, 1'b0, 2'd3);
    runTxn("rr4", 4'b1111, 4'b0001, 8'd0, 1'b0, 2'd0);
    runTxn("rr5", 4'b1111, 4'b0010, 8'd1, 1'b0, 2'd1);

    // Pointer wrap: grant 2, then 3 and 0 out of 1001, then lone requester 1
    runTxn("wrap_g2", 4'b1111, 4'b0100, 8'd2, 1'b0, 2'd2);
    runTxn("wrap_g3", 4'b1001, 4'b1000, 8'd3, 1'b0, 2'd3);
    runTxn("wrap_g0", 4'b1001, 4'b0001, 8'd0, 1'b0, 2'd0);
    runTxn("wrap_g1", 4'b0010, 4'b0010, 8'd1, 1'b0, 2'd1);

    // Backpressure: pointer now 2, requester 2 sums to 60
    applyStimulus(2, 8'd10, 8'd20, 8'd30);
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    #1;
    checkOutput("bp.grant", 32'(req_ready), 32'h4);
    step();
    step();
    checkOutput("bp.rsp_valid", 32'(rsp_valid), 32'h1);
    for (int n = 0; n < 5; n++) begin
      step();
      checkOutput($sformatf("bp.hold_valid%0d", n), 32'(rsp_valid), 32'h1);
      checkOutput($sformatf("bp.hold_sum%0d", n),   32'(rsp_sum),   32'd60);
      checkOutput($sformatf("bp.hold_id%0d", n),    32'(rsp_id),    32'd2);
      checkOutput($sformatf("bp.hold_ready%0d", n), 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("bp.valid_done", 32'(rsp_valid), 32'h0);
    checkOutput("bp.next_grant", 32'(req_ready), 32'h8);
    step();
    checkOutput("bp.busy_next", 32'(busy), 32'h1);
    step();
    checkOutput("bp.next_id",  32'(rsp_id),  32'd3);
    checkOutput("bp.next_sum", 32'(rsp_sum), 32'd3);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("bp.next_done", 32'(rsp_valid), 32'h0);

    // Reset while in CALC: the in-flight request must vanish
    applyStimulus(1, 8'd5, 8'd5, 8'd5);
    req_valid = 4'b0010;
    #1;
    checkOutput("mid.grant", 32'(req_ready), 32'h2);
    step();
    checkOutput("mid.busy_calc", 32'(busy), 32'h1);
    rst_n     = 1'b0;
    req_valid = 4'b0110;
    step();
    checkOutput("mid.ready_in_reset", 32'(req_ready), 32'h0);
    checkOutput("mid.rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("mid.rsp_sum",   32'(rsp_sum),   32'h0);
    checkOutput("mid.rsp_ovf",   32'(rsp_ovf),   32'h0);
    checkOutput("mid.rsp_id",    32'(rsp_id),    32'h0);
    checkOutput("mid.busy",      32'(busy),      32'h0);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      step();
      checkOutput($sformatf("mid.no_rsp%0d", n), 32'(rsp_valid), 32'h0);
    end
    runTxn("mid_after", 4'b0110, 4'b0010, 8'd15, 1'b0, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
